// File: rtl/booth_digit_serializer_if.sv
// Handshake bundle for the Booth digit serializer: operand in, signed digits out.
interface booth_digit_serializer_if #(
   parameter int WIDTH = 8,
   parameter int IW    = $clog2(WIDTH/2+1)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic             mode;
   logic             dig_valid;
   logic             dig_ready;
   logic [2:0]       digit;
   logic [IW-1:0]    dig_idx;
   logic             dig_last;

   modport master (
      output in_valid, x, mode, dig_ready,
      input  in_ready, dig_valid, digit, dig_idx, dig_last
   );

   modport slave (
      input  in_valid, x, mode, dig_ready,
      output in_ready, dig_valid, digit, dig_idx, dig_last
   );
endinterface

// File: rtl/booth_digit_serializer.sv
// Radix-4 Booth digit serializer: loads one operand and streams its signed digits
// (sign-magnitude, -2..+2) least-significant first, signed or unsigned interpretation.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready high
// EMIT   | presenting digit dig_idx, waiting for dig_ready
module booth_digit_serializer #(
   parameter int WIDTH = 8,
   parameter int NDIG  = WIDTH/2,
   parameter int IW    = $clog2(WIDTH/2+1)
) (
   input logic                     clk,
   input logic                     rst,
   booth_digit_serializer_if.slave bus
);
   localparam logic [0:0]    S_IDLE   = 1'b0;
   localparam logic [0:0]    S_EMIT   = 1'b1;
   localparam logic [IW-1:0] LAST_SGN = IW'(NDIG-1);
   localparam logic [IW-1:0] LAST_UNS = IW'(NDIG);

   logic [0:0]    state_q, state_d;
   logic [WIDTH:0] sr_q, sr_d;
   logic          mode_q, mode_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] last_q, last_d;
   logic          load, take, is_last, fill;
   logic [2:0]    digit_w;

   assign is_last = (idx_q == last_q);
   assign load    = bus.in_valid && (state_q == S_IDLE) && !rst;
   assign take    = (state_q == S_EMIT) && bus.dig_ready;
   // Sign extension replicates the operand MSB, which stays parked in sr_q[WIDTH].
   assign fill    = mode_q & sr_q[WIDTH];

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               state_d = S_EMIT;
               sr_d    = {bus.x, 1'b0};
               mode_d  = bus.mode;
               idx_d   = '0;
               last_d  = bus.mode ? LAST_SGN : LAST_UNS;
            end
         end
         default: begin
            if (take) begin
               if (is_last) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  sr_d  = {fill, fill, sr_q[WIDTH:2]};
                  idx_d = idx_q + IW'(1);
               end
            end
         end
      endcase
   end

   always_comb begin
      digit_w = 3'b000;
      case (sr_q[2:0])
         3'b001, 3'b010: digit_w = 3'b001;
         3'b011:         digit_w = 3'b010;
         3'b100:         digit_w = 3'b110;
         3'b101, 3'b110: digit_w = 3'b101;
         default:        digit_w = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         mode_q  <= 1'b0;
         idx_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE) && !rst;
   assign bus.dig_valid = (state_q == S_EMIT);
   assign bus.digit     = digit_w;
   assign bus.dig_idx   = idx_q;
   assign bus.dig_last  = (state_q == S_EMIT) && is_last;
endmodule

// File: tb/tb_booth_digit_serializer.sv
// Directed and randomized checks of the Booth digit serializer (WIDTH 8 and 16).
module tb_booth_digit_serializer;
   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_cnt = 0;
   int   accept_cyc;
   int   send_to = 0;

   logic [2:0] cap_d [16];
   int         cap_i [16];
   logic       cap_l [16];
   int         n_cap, vcyc, hold_err;
   bit         coll_to;

   booth_digit_serializer_if #(.WIDTH(8))  b8 ();
   booth_digit_serializer_if #(.WIDTH(16)) b16 ();

   booth_digit_serializer #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
   booth_digit_serializer #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic send(input logic [7:0] xv, input logic md);
      int t = 0;
      b8.x = xv; b8.mode = md; b8.in_valid = 1'b1;
      while (b8.in_ready !== 1'b1 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 20) send_to++;
      @(posedge clk); #1;
      accept_cyc = cyc_cnt;
      b8.in_valid = 1'b0;
   endtask

   // pat 0: dig_ready always high; pat 1: dig_ready 1,0,0 repeating
   task automatic collect(input int pat, input int pulse_cyc);
      int cyc = 0;
      bit done = 0;
      bit held = 0;
      logic [2:0] hd;
      logic [2:0] hi;
      n_cap = 0; vcyc = 0; hold_err = 0; coll_to = 0;
      while (!done && cyc < 60) begin
         b8.dig_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (cyc == pulse_cyc) begin
            b8.in_valid = 1'b1; b8.x = 8'hAA; b8.mode = 1'b1;
         end else b8.in_valid = 1'b0;
         if (held && (b8.digit !== hd || b8.dig_idx !== hi)) hold_err++;
         held = 0;
         if (b8.dig_valid === 1'b1) begin
            vcyc++;
            if (b8.dig_ready) begin
               cap_d[n_cap] = b8.digit; cap_i[n_cap] = int'(b8.dig_idx); cap_l[n_cap] = b8.dig_last;
               n_cap++;
               if (b8.dig_last === 1'b1 || n_cap >= 16) done = 1;
            end else begin
               held = 1; hd = b8.digit; hi = b8.dig_idx;
            end
         end
         @(posedge clk); #1; cyc++;
      end
      b8.dig_ready = 1'b0; b8.in_valid = 1'b0;
      if (!done) coll_to = 1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({b8.in_ready, b8.dig_valid, b8.digit, b8.dig_idx, b8.dig_last} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy/vld/dig/idx/last=%b expected 000000000",
                     {b8.in_ready, b8.dig_valid, b8.digit, b8.dig_idx, b8.dig_last});
         end
      end
      rst = 1'b0; #1;
      n_cmp++;
      if (b8.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL ready_after_reset: got %b expected 1", b8.in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (b8.dig_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL idle_quiet: got vld=%b rdy=%b expected 0/1", b8.dig_valid, b8.in_ready);
         end
      end
   endtask

   task automatic test_signed_13;
      logic [2:0] ed [4] = '{3'b001, 3'b101, 3'b001, 3'b000};
      send(8'd13, 1'b1);
      collect(0, -1);
      n_cmp++;
      if ({coll_to, n_cap, vcyc} !== {1'b0, 32'd4, 32'd4}) begin
         n_bad++; $display("FAIL s13_count: got to=%0d n=%0d vcyc=%0d expected 0/4/4", coll_to, n_cap, vcyc);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (cap_d[i] !== ed[i] || cap_i[i] != i || cap_l[i] !== (i == 3)) begin
            n_bad++;
            $display("FAIL s13_digit%0d: got dig=%b idx=%0d last=%b expected dig=%b idx=%0d last=%b",
                     i, cap_d[i], cap_i[i], cap_l[i], ed[i], i, (i == 3));
         end
      end
      n_cmp++;
      if (b8.dig_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL s13_return_idle: got vld=%b rdy=%b expected 0/1", b8.dig_valid, b8.in_ready);
      end
   endtask

   task automatic test_patterns;
      logic [7:0]  vx [4] = '{8'hFF, 8'hFF, 8'h80, 8'h55};
      logic        vm [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int          vn [4] = '{4, 5, 4, 4};
      logic [14:0] vd [4] = '{15'b000_000_000_000_101, 15'b001_000_000_000_101,
                              15'b000_110_000_000_000, 15'b000_001_001_001_001};
      logic [2:0]  ed;
      for (int p = 0; p < 4; p++) begin
         send(vx[p], vm[p]);
         collect(0, -1);
         n_cmp++;
         if (coll_to !== 1'b0 || n_cap != vn[p] || vcyc != vn[p]) begin
            n_bad++;
            $display("FAIL pat%0d_count: got to=%0d n=%0d vcyc=%0d expected 0/%0d/%0d",
                     p, coll_to, n_cap, vcyc, vn[p], vn[p]);
         end
         for (int i = 0; i < vn[p]; i++) begin
            ed = 3'(vd[p] >> (3*i));
            n_cmp++;
            if (cap_d[i] !== ed || cap_i[i] != i || cap_l[i] !== (i == vn[p]-1)) begin
               n_bad++;
               $display("FAIL pat%0d_digit%0d: got dig=%b idx=%0d last=%b expected dig=%b idx=%0d last=%b",
                        p, i, cap_d[i], cap_i[i], cap_l[i], ed, i, (i == vn[p]-1));
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [2:0] ed [4] = '{3'b001, 3'b101, 3'b001, 3'b000};
      send(8'd13, 1'b1);
      collect(1, 2);
      n_cmp++;
      if (coll_to !== 1'b0 || n_cap != 4 || vcyc != 10 || hold_err != 0) begin
         n_bad++;
         $display("FAIL bp_count: got to=%0d n=%0d vcyc=%0d holderr=%0d expected 0/4/10/0",
                  coll_to, n_cap, vcyc, hold_err);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (cap_d[i] !== ed[i] || cap_i[i] != i || cap_l[i] !== (i == 3)) begin
            n_bad++;
            $display("FAIL bp_digit%0d: got dig=%b idx=%0d last=%b expected dig=%b idx=%0d last=%b",
                     i, cap_d[i], cap_i[i], cap_l[i], ed[i], i, (i == 3));
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (b8.dig_valid !== 1'b0) begin
         n_bad++; $display("FAIL bp_pulse_ignored: got vld=%b expected 0", b8.dig_valid);
      end
   endtask

   task automatic test_back_to_back;
      int a0, a1, a2;
      send_to = 0;
      send(8'h55, 1'b1); a0 = accept_cyc; collect(0, -1);
      send(8'd13, 1'b0); a1 = accept_cyc; collect(0, -1);
      n_cmp++;
      if (n_cap != 5 || cap_d[4] !== 3'b000 || cap_l[4] !== 1'b1) begin
         n_bad++; $display("FAIL b2b_unsigned13: got n=%0d top=%b last=%b expected 5/000/1", n_cap, cap_d[4], cap_l[4]);
      end
      send(8'h55, 1'b1); a2 = accept_cyc; collect(0, -1);
      n_cmp++;
      if (a1 - a0 != 5 || a2 - a1 != 6 || send_to != 0) begin
         n_bad++; $display("FAIL b2b_spacing: got %0d/%0d to=%0d expected 5/6/0", a1 - a0, a2 - a1, send_to);
      end
   endtask

   task automatic test_reset_midstream;
      send(8'd13, 1'b1);
      b8.dig_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({b8.in_ready, b8.dig_valid, b8.digit, b8.dig_idx, b8.dig_last} !== 9'b0) begin
         n_bad++;
         $display("FAIL midreset_state: got rdy/vld/dig/idx/last=%b expected 000000000",
                  {b8.in_ready, b8.dig_valid, b8.digit, b8.dig_idx, b8.dig_last});
      end
      rst = 1'b0; b8.dig_ready = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (b8.dig_valid !== 1'b0) begin
         n_bad++; $display("FAIL midreset_no_digits: got vld=%b expected 0", b8.dig_valid);
      end
      send(8'h55, 1'b1);
      collect(0, -1);
      n_cmp++;
      if (n_cap != 4 || cap_i[0] != 0 || cap_d[0] !== 3'b001 || cap_d[3] !== 3'b001 || cap_l[3] !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_restart: got n=%0d idx0=%0d d0=%b d3=%b last=%b expected 4/0/001/001/1",
                  n_cap, cap_i[0], cap_d[0], cap_d[3], cap_l[3]);
      end
   endtask

   task automatic test_random_w16;
      logic [15:0] xv;
      logic        md;
      longint      sum, expv;
      int          nd, t, val;
      bit          ok, done;
      for (int k = 0; k < 1000; k++) begin
         xv = 16'($urandom); md = 1'($urandom_range(0, 1));
         sum = 0; nd = 0; t = 0; ok = 1; done = 0;
         b16.x = xv; b16.mode = md; b16.in_valid = 1'b1; b16.dig_ready = 1'b1;
         while (b16.in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
         end
         @(posedge clk); #1;
         b16.in_valid = 1'b0;
         t = 0;
         while (!done && t < 30) begin
            if (b16.dig_valid === 1'b1) begin
               if (b16.dig_idx !== 4'(nd) || b16.digit === 3'b100 || b16.digit[1:0] === 2'b11) ok = 0;
               val = b16.digit[2] ? -int'(b16.digit[1:0]) : int'(b16.digit[1:0]);
               sum += longint'(val) * (longint'(1) << (2*nd));
               if (b16.dig_last === 1'b1) done = 1;
               nd++;
            end
            @(posedge clk); #1; t++;
         end
         expv = md ? longint'($signed(xv)) : longint'(xv);
         n_cmp++;
         if (sum != expv || !done || !ok || nd != (md ? 8 : 9)) begin
            n_bad++;
            $display("FAIL w16_op%0d: x=%h mode=%b got sum=%0d n=%0d ok=%0d done=%0d expected sum=%0d n=%0d",
                     k, xv, md, sum, nd, ok, done, expv, (md ? 8 : 9));
         end
      end
      b16.dig_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b8.in_valid = 1'b0;  b8.x = '0;  b8.mode = 1'b0;  b8.dig_ready = 1'b0;
      b16.in_valid = 1'b0; b16.x = '0; b16.mode = 1'b0; b16.dig_ready = 1'b0;
      test_reset;
      test_signed_13;
      test_patterns;
      test_backpressure;
      test_back_to_back;
      test_reset_midstream;
      test_random_w16;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/booth_digit_serializer.md
# booth_digit_serializer

Parametrised, sequential successor to the combinational radix-4 signed-digit encoder in the Goldschmidt datapath. It accepts one WIDTH-bit operand per handshake. It streams its radix-4 Booth digits (values −2..+2), least-significant digit first, one digit per accepted transfer. Both two's-complement and unsigned operands are supported. It feeds the digit-serial partial-product stage of the Goldschmidt multiplier.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 4
- NDIG, WIDTH/2, number of signed digits emitted in signed mode; unsigned mode emits NDIG+1
- IW, $clog2(WIDTH/2+1), width of dig_idx

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand x is valid
- in_ready  out  1  block can accept an operand
- x  in  WIDTH  operand
- mode  in  1  sampled with x: 1 = two's complement, 0 = unsigned
- dig_valid  out  1  digit output is valid
- dig_ready  in  1  consumer accepts the digit
- digit  out  3  sign-magnitude digit: [2] = sign (1 = negative), [1:0] = magnitude 0/1/2; zero is always 3'b000, never 3'b100
- dig_idx  out  IW  index of the current digit, 0 = least significant
- dig_last  out  1  current digit is the final digit of the operand

## Operation
- Digit i value = −2·b[2i+1] + b[2i] + b[2i−1], with b[−1] = 0.
- Signed mode: bits above WIDTH−1 are sign-extended. Digits 0..NDIG−1 are emitted.
- Unsigned mode: bits above WIDTH−1 are zero. Digits 0..NDIG are emitted. The top digit equals b[WIDTH−1] and is always 0 or +1.
- The sum of digit_i·4^i equals x, interpreted per mode, exactly.
- Datapath: a WIDTH+1-bit shift register holds {x, guard bit}. It is loaded with {x, 1'b0}. On each accepted digit it shifts right by 2, with fill bits = sign bit (mode 1) or 0 (mode 0). The digit is decoded from the low 3 bits of the register.
- Registers captured on load: the mode bit and the digit count (NDIG or NDIG+1).
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, load the operand → EMIT.
  - EMIT: dig_valid = 1. On dig_valid && dig_ready: if dig_last → IDLE, else shift and increment dig_idx.
- No digit is skipped even when its value is zero. The consumer always sees the full count.
- in_valid is ignored while in EMIT, and x and mode are not sampled then.
- digit, dig_idx and dig_last are held stable while dig_valid && !dig_ready.

## Timing
- Reset values, while rst is high and on the cycle after: state IDLE; dig_valid = 0; digit = 3'b000; dig_idx = 0; dig_last = 0; shift register = 0.
- in_ready is 0 while rst is high. in_ready is 1 from the first cycle after rst deasserts.
- Latency: an operand accepted at edge k gives dig_valid = 1 and digit 0 in the cycle following edge k. All outputs are registered.
- With dig_ready held high:
  - Signed mode emits one digit per cycle for NDIG cycles, then one IDLE cycle.
  - Throughput is one operand per NDIG+1 cycles, or NDIG+2 cycles in unsigned mode.
- On the edge that accepts the last digit, dig_valid falls and in_ready rises in the next cycle. A back-to-back operand is accepted one cycle later, with no combinational ready path.
- Backpressure: dig_ready low stalls indefinitely with no state change.
- rst asserted mid-operand aborts the operand. The next cycle shows the reset values, and no further digits of that operand appear.
- rst has priority over any simultaneous handshake.

## Test plan
- Reset then idle: rst high 3 cycles → dig_valid = 0, digit = 000, dig_idx = 0, in_ready = 0 during reset and 1 after; no digits appear without in_valid.
- x = 8'd13, mode = 1, dig_ready = 1 → digits 001, 101, 001, 000 with idx 0..3, dig_last only on idx 3, dig_valid high exactly 4 cycles.
- x = 8'hFF: mode = 1 → 101, 000, 000, 000 (−1); mode = 0 → 101, 000, 000, 000, 001 (255), dig_last on idx 4.
- x = 8'h80, mode = 1 → 000, 000, 000, 110 (−128); x = 8'h55 → 001 ×4 (85).
- Backpressure: x = 13 signed with dig_ready toggling 1,0,0,1,… → digit and idx held during stalls; the same 4-digit sequence results; in_valid pulsed during EMIT with x = 8'hAA is ignored.
- Reset mid-stream after digit 1 → dig_valid = 0 the next cycle; a new operand x = 8'h55 then streams cleanly from idx 0. A randomized WIDTH = 16 run checks Σ digit_i·4^i = x in both modes across 1000 operands.
